vga_timing_gen: RTL

//  Parametrised VGA raster engine; successor to the fixed 640x480 VGA top.

---
 rtl/vga_pkg.sv | 49 ++++
 rtl/vga_axis_cnt.sv | 61 ++++++
 rtl/vga_timing_gen.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA raster engine:
//     - default 640x480@60 timing constants,
//     - axis total / counter-width helper functions,
//     - colour-bar lookup used by the optional test pattern.
// ---------------------------------------------------------------------------
package vga_pkg;

    // Default 640x480@60 timing (25 MHz pixel clock from 100 MHz mclk)
    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Which channels a colour bar lights up
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } bar_mask_t;

    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Minimal counter width for values 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bar k: bit 2 lights red, bit 1 green, bit 0 blue
    function automatic bar_mask_t colour_bar(input logic [2:0] k);
        bar_mask_t m;
        m.r = k[2];
        m.g = k[1];
        m.b = k[0];
        return m;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// ---------------------------------------------------------------------------
// vga_axis_cnt
//   One raster axis (used once for horizontal, once for vertical).
//   Counts 0..TOTAL-1 while en_i is high and decodes the axis window flags.
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous reset, active low (counter -> 0)
//   en_i      in   advance the counter by one position this cycle
//   cnt_o     out  current position
//   active_o  out  cnt_o < ACTIVE
//   sync_o    out  sync level for cnt_o (POL inside the sync window, ~POL outside)
//   wrap_o    out  cnt_o is at its last position (TOTAL-1)
// ---------------------------------------------------------------------------
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_LEN   = 96,
    parameter int unsigned ACTIVE     = 640,
    parameter bit          POL        = 1'b0,
    localparam int unsigned W         = cnt_width(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         active_o,
    output logic         sync_o,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [31:0]  cnt_ext;

    // Window bounds can reach TOTAL itself, so compare at 32 bits
    assign cnt_ext = 32'(cnt_q);

    assign wrap_o   = (cnt_q == W'(TOTAL - 1));
    assign active_o = (cnt_ext < ACTIVE);
    assign sync_o   = ((cnt_ext >= SYNC_START) && (cnt_ext < SYNC_START + SYNC_LEN)) ? POL : ~POL;
    assign cnt_o    = cnt_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster engine. Divides mclk to a pixel tick (pe), runs
//   the horizontal/vertical counters, asks the upstream source for the colour
//   of (pix_x, pix_y) and registers colour and syncs together so they reach
//   the pins aligned, exactly one pixel tick after the counters.
// Ports
//   mclk          in   system clock
//   rst_n         in   asynchronous reset, active low
//   tp_sel        in   colour-bar test pattern select (VGA_TEST_PATTERN_EN only)
//   pix_x/pix_y   out  current column / line
//   pix_req       out  current position is visible; upstream drives in_*
//   in_r/g/b      in   upstream colour, sampled on pe while pix_req=1
//   Hsync/Vsync   out  registered syncs (HS_POL/VS_POL = active level)
//   OutRed/Green/Blue out registered colour, black during blanking
//   frame_start   out  one-mclk pulse on the last pixel tick of each frame
//   Led           out  heartbeat, toggles every LED_FRAMES frames
// Configuration
//   VGA_TEST_PATTERN_EN: adds tp_sel, which swaps in_* for 8 vertical bars.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned RW         = 3,
    parameter int unsigned GW         = 3,
    parameter int unsigned BW         = 2,
    parameter int unsigned LED_FRAMES = 60,
    localparam int unsigned H_TOTAL   = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL   = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned XW        = cnt_width(H_TOTAL),
    localparam int unsigned YW        = cnt_width(V_TOTAL)
) (
    input  logic          mclk,
    input  logic          rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic          tp_sel,
`endif
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          pix_req,
    input  logic [RW-1:0] in_r,
    input  logic [GW-1:0] in_g,
    input  logic [BW-1:0] in_b,
    output logic          Hsync,
    output logic          Vsync,
    output logic [RW-1:0] OutRed,
    output logic [GW-1:0] OutGreen,
    output logic [BW-1:0] OutBlue,
    output logic          frame_start,
    output logic          Led
);

    localparam int unsigned PW = cnt_width(CLK_DIV);
    localparam int unsigned FW = cnt_width(LED_FRAMES);

    logic [PW-1:0] presc_q, presc_d;
    logic          pe;

    logic          h_active, h_sync, h_wrap;
    logic          v_active, v_sync, v_wrap;

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic [RW-1:0] red_q, red_d;
    logic [GW-1:0] green_q, green_d;
    logic [BW-1:0] blue_q, blue_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          led_q, led_d;

    logic [RW-1:0] src_r;
    logic [GW-1:0] src_g;
    logic [BW-1:0] src_b;

    // ---------------- pixel-tick prescaler ----------------
    // With CLK_DIV=1 the count stays at 0 and pe is high every cycle.
    assign pe = (presc_q == PW'(CLK_DIV - 1));

    always_comb begin
        presc_d = pe ? '0 : presc_q + 1'b1;
    end

    // ---------------- raster counters ----------------
    vga_axis_cnt #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC),
        .ACTIVE     (H_ACTIVE),
        .POL        (HS_POL)
    ) u_h_cnt (
        .clk      (mclk),
        .rst_n    (rst_n),
        .en_i     (pe),
        .cnt_o    (pix_x),
        .active_o (h_active),
        .sync_o   (h_sync),
        .wrap_o   (h_wrap)
    );

    // Vertical advances only when the line wraps, so both wrap on the same tick.
    vga_axis_cnt #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC),
        .ACTIVE     (V_ACTIVE),
        .POL        (VS_POL)
    ) u_v_cnt (
        .clk      (mclk),
        .rst_n    (rst_n),
        .en_i     (pe & h_wrap),
        .cnt_o    (pix_y),
        .active_o (v_active),
        .sync_o   (v_sync),
        .wrap_o   (v_wrap)
    );

    assign pix_req     = h_active & v_active;
    assign frame_start = pe & h_wrap & v_wrap;

    // ---------------- colour source ----------------
`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [31:0] bar_idx;
    logic [2:0]  bar_k;
    bar_mask_t   bar;

    // Columns past the eighth bar (H_ACTIVE not a multiple of 8) stay on bar 7.
    assign bar_idx = 32'(pix_x) / BAR_W;
    assign bar_k   = (bar_idx > 32'd7) ? 3'd7 : bar_idx[2:0];
    assign bar     = colour_bar(bar_k);

    always_comb begin
        src_r = in_r;
        src_g = in_g;
        src_b = in_b;
        if (tp_sel) begin
            src_r = {RW{bar.r}};
            src_g = {GW{bar.g}};
            src_b = {BW{bar.b}};
        end
    end
`else
    always_comb begin
        src_r = in_r;
        src_g = in_g;
        src_b = in_b;
    end
`endif

    // ---------------- pin registers ----------------
    // Syncs and colour all capture the same counter state on pe, which is
    // what keeps them aligned one pixel tick behind pix_x/pix_y.
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        if (pe) begin
            hsync_d = h_sync;
            vsync_d = v_sync;
            if (pix_req) begin
                red_d   = src_r;
                green_d = src_g;
                blue_d  = src_b;
            end else begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
            end
        end
    end

    // ---------------- heartbeat ----------------
    always_comb begin
        frm_d = frm_q;
        led_d = led_q;
        if (frame_start) begin
            if (frm_q == FW'(LED_FRAMES - 1)) begin
                frm_d = '0;
                led_d = ~led_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            frm_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            frm_q   <= frm_d;
            led_q   <= led_d;
        end
    end

    assign Hsync    = hsync_q;
    assign Vsync    = vsync_q;
    assign OutRed   = red_q;
    assign OutGreen = green_q;
    assign OutBlue  = blue_q;
    assign Led      = led_q;

endmodule
